dmem_bus_bridge: RTL
====================

Name: dmem_bus_bridge

Overview:
- Sits between the MEM stage's data-memory request (ce/we/addr/wtData/w_mask/r_mask) and an external, variable-latency data bus using a request/grant/rvalid handshake.
- Replaces the zero-latency DataMem path for memories that cannot answer in one cycle.
- Holds the single-cycle core with a `stall` output until each access completes.
- Returns read data with unselected byte lanes zeroed, and enforces a timeout.

Parameters:
- TIMEOUT, 255, maximum cycles spent in REQ plus WAIT_R before the access is aborted (1..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout or bus error.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- memCe  in  1  access request from the MEM stage
- memWr  in  1  write request (1 = store)
- memRr  in  1  read request (1 = load)
- memAddr  in  32  byte address
- wtData  in  32  store data
- w_mask  in  4  store byte-lane enables
- r_mask  in  4  load byte-lane enables
- rdData  out  32  load data to the MEM stage
- stall  out  1  freeze PC/pipeline while high
- err  out  1  one-cycle pulse: access aborted
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address
- bus_wdata  out  32  write data
- bus_wstrb  out  4  write strobes
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data
- bus_err  in  1  bus error, sampled with gnt (writes) or rvalid (reads)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all outputs 0, latched request cleared, timeout counter 0. A reset during REQ drops bus_req immediately, without waiting for a clock edge.
- States are IDLE, REQ, WAIT_R, DONE.
- IDLE
  - stall = memCe (combinational).
  - If memCe=1 at the edge, latch the request and go to REQ:
    - addr → {memAddr[31:2],2'b00}
    - we = memWr & ~memRr
    - wdata, w_mask, r_mask latched as presented
  - memCe=1 with memWr=memRr=0 is treated as a read.
- REQ
  - bus_req=1; bus_we, bus_addr, bus_wdata, bus_wstrb driven from the latch. bus_wstrb=0 for reads.
  - Bus outputs are held stable until bus_gnt.
  - On gnt with a write: go to DONE; err flag set if bus_err.
  - On gnt with a read: go to WAIT_R.
  - stall=1.
- WAIT_R
  - bus_req=0.
  - On bus_rvalid: rd_latch = bus_rdata with lane i zeroed where r_mask[i]=0, then go to DONE.
  - If bus_err is also set, rd_latch = ERR_DATA and the err flag is set.
  - bus_rvalid is ignored in any other state. rvalid is never expected in the gnt cycle.
  - stall=1.
- DONE
  - stall=0, so the core commits the instruction this cycle.
  - rdData = rd_latch.
  - err = err flag.
  - Next state is always IDLE. Flag cleared on exit.
- rdData holds its last value in IDLE/REQ/WAIT_R. It is valid only in DONE.
- Latched request fields are frozen from IDLE exit to DONE exit; memCe and the other inputs are ignored during that window.
- Timeout
  - Counter clears on IDLE→REQ and increments every cycle in REQ or WAIT_R.
  - When the counter equals TIMEOUT-1 and no completion occurs that cycle: go to DONE, rd_latch=ERR_DATA, err flag=1, bus_req dropped.
  - Completion in the same cycle as expiry wins: normal result, no err.
- Minimum latency (cycles with stall=1 before the DONE cycle):
  - write: 2 (IDLE, REQ with gnt)
  - read: 3 (IDLE, REQ, WAIT_R with rvalid)
- Back-to-back accesses: after DONE, a new memCe in IDLE starts a fresh access. There is no bypass from DONE.

Decomposition:
- Shared package dmem_bus_pkg:
  - state enum {IDLE, REQ, WAIT_R, DONE}
  - ERR_DATA default constant
  - lane-mask function mask_lanes(data, mask)
- One sub-module, dmem_timeout_ctr (clear / enable / expire), 8-bit counter.
- FSM, request latch and read-data latch stay in the top.

Test Plan:
- Write with gnt on the first REQ cycle: addr=0x0000_1006, wtData=0x1122_3344, w_mask=4'b1100 → bus_addr=0x0000_1004, bus_wstrb=4'b1100, bus_wdata=0x1122_3344; stall=1 for 2 cycles; DONE on cycle 3 with err=0.
- Read with gnt delayed 3 cycles and rvalid 2 cycles after gnt: bus_rdata=0xAABB_CCDD, r_mask=4'b0011 → rdData=0x0000_CCDD in DONE; stall=1 for exactly 7 cycles.
- Timeout with TIMEOUT=8 and bus_gnt held 0 → bus_req drops after 8 REQ cycles; DONE with rdData=0xDEAD_BEEF, err pulse of exactly 1 cycle; next memCe restarts normally.
- Reset mid-WAIT_R: assert rst=0 between edges → bus_req, stall and err go to 0 immediately; state IDLE; a late bus_rvalid after reset release is ignored.
- Two loads back-to-back: each shows its own DONE cycle with the correct rdData; bus_addr changes only after the first DONE; the inputs of the second load are not latched during the first access.
- Bus error on a read (rvalid=1, bus_err=1) → rdData=0xDEAD_BEEF, err=1 for one cycle in DONE.

Source files
------------

// File: rtl/dmem_bus_pkg.sv
// Shared types and helpers for the data-memory bus bridge.
package dmem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic logic [31:0] mask_lanes(input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = mask[i] ? data[i*8 +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Access watchdog: counts cycles while enabled and flags the last allowed cycle.
module dmem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;

  // Cycle counter, restarted at the start of every access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expire = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges the MEM-stage data request onto a request/grant/rvalid bus,
// stalling the single-cycle core until each access completes or times out.
module dmem_bus_bridge
  import dmem_bus_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memCe,
  input  logic        memWr,
  input  logic        memRr,
  input  logic [31:0] memAddr,
  input  logic [31:0] wtData,
  input  logic [3:0]  w_mask,
  input  logic [3:0]  r_mask,
  output logic [31:0] rdData,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic [3:0]  r_rmask;
  logic [31:0] r_rd;
  logic        r_err;
  logic        w_clr;
  logic        w_en;
  logic        w_expire;
  logic        w_complete;

  assign w_clr = (r_state == IDLE) && memCe;
  assign w_en  = (r_state == REQ) || (r_state == WAIT_R);

  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .o_expire (w_expire)
  );

  // A read grant is not a completion: it only hands over to WAIT_R.
  always_comb begin
    w_complete = 1'b0;
    case (r_state)
      REQ:     w_complete = bus_gnt && r_we;
      WAIT_R:  w_complete = bus_rvalid;
      default: w_complete = 1'b0;
    endcase
  end

  // Next-state logic; completion takes priority over expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (memCe) w_next = REQ;
        else       w_next = IDLE;
      end
      REQ: begin
        if (w_complete)    w_next = DONE;
        else if (w_expire) w_next = DONE;
        else if (bus_gnt)  w_next = WAIT_R;
        else               w_next = REQ;
      end
      WAIT_R: begin
        if (w_complete || w_expire) w_next = DONE;
        else                        w_next = WAIT_R;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Request latch, read-data latch and abort flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_wmask <= 4'b0000;
      r_rmask <= 4'b0000;
      r_rd    <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (memCe) begin
            r_we    <= memWr & ~memRr;
            r_addr  <= {memAddr[31:2], 2'b00};
            r_wdata <= wtData;
            r_wmask <= w_mask;
            r_rmask <= r_mask;
            r_err   <= 1'b0;
          end
        end
        REQ: begin
          if (w_complete) begin
            r_err <= bus_err;
          end else if (w_expire) begin
            r_rd  <= ERR_DATA;
            r_err <= 1'b1;
          end
        end
        WAIT_R: begin
          if (bus_rvalid) begin
            r_rd  <= bus_err ? ERR_DATA : mask_lanes(bus_rdata, r_rmask);
            r_err <= bus_err;
          end else if (w_expire) begin
            r_rd  <= ERR_DATA;
            r_err <= 1'b1;
          end
        end
        DONE:    r_err <= 1'b0;
        default: r_err <= 1'b0;
      endcase
    end
  end

  // Stall follows memCe only while idle; reset forces it low.
  always_comb begin
    stall = 1'b0;
    case (r_state)
      IDLE:    stall = memCe & rst;
      REQ:     stall = 1'b1;
      WAIT_R:  stall = 1'b1;
      DONE:    stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  assign bus_req   = (r_state == REQ);
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_wstrb = r_we ? r_wmask : 4'b0000;
  assign rdData    = r_rd;
  assign err       = (r_state == DONE) && r_err;

endmodule
